// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg : shared widths, memory-op opcodes and writeback record type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam int DW = 16;
  localparam int RW = 4;

  localparam logic [3:0] OP_ATYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1000;

  typedef struct packed {
    logic          en;
    logic [RW-1:0] dest;
    logic [DW-1:0] data;
  } wb_rec_t;

  // Exactly one strobe selects a memory op; anything else falls back to A-type.
  function automatic logic [3:0] mem_op(input logic rd, input logic wr);
    logic [3:0] op;
    op = OP_ATYPE;
    if (rd && !wr) op = OP_LW;
    else if (wr && !rd) op = OP_SW;
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if : EX/MEM-side record and writeback bundle for mem_wb_stage
// Optional forwarding outputs under WB_FWD_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_wb_stage_if #(
  parameter int DW = pipe_pkg::DW,
  parameter int RW = pipe_pkg::RW
);

  logic          in_valid;
  logic          in_cntrl_m5;
  logic [DW-1:0] in_m5;
  logic [DW-1:0] in_addr_mem;
  logic [DW-1:0] in_data_mem;
  logic          in_cntrl_mem_read;
  logic          in_cntrl_mem_write;
  logic [RW-1:0] in_dest_reg;

  logic [DW-1:0] out_wb_data;
  logic [RW-1:0] out_wb_reg;
  logic          out_wb_en;
  logic          out_mem_err;

`ifdef WB_FWD_EN
  logic          out_fwd_valid;
  logic [RW-1:0] out_fwd_reg;
  logic [DW-1:0] out_fwd_data;

  modport master (
    output in_valid, in_cntrl_m5, in_m5, in_addr_mem, in_data_mem,
           in_cntrl_mem_read, in_cntrl_mem_write, in_dest_reg,
    input  out_wb_data, out_wb_reg, out_wb_en, out_mem_err,
           out_fwd_valid, out_fwd_reg, out_fwd_data
  );

  modport slave (
    input  in_valid, in_cntrl_m5, in_m5, in_addr_mem, in_data_mem,
           in_cntrl_mem_read, in_cntrl_mem_write, in_dest_reg,
    output out_wb_data, out_wb_reg, out_wb_en, out_mem_err,
           out_fwd_valid, out_fwd_reg, out_fwd_data
  );
`else
  modport master (
    output in_valid, in_cntrl_m5, in_m5, in_addr_mem, in_data_mem,
           in_cntrl_mem_read, in_cntrl_mem_write, in_dest_reg,
    input  out_wb_data, out_wb_reg, out_wb_en, out_mem_err
  );

  modport slave (
    input  in_valid, in_cntrl_m5, in_m5, in_addr_mem, in_data_mem,
           in_cntrl_mem_read, in_cntrl_mem_write, in_dest_reg,
    output out_wb_data, out_wb_reg, out_wb_en, out_mem_err
  );
`endif

endinterface

`default_nettype wire

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array : DEPTH x DW data memory, async read, sync write, no reset
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_array #(
  parameter int DW    = 16,
  parameter int DEPTH = 256
) (
  input  wire logic                     clk,
  input  wire logic                     we,
  input  wire logic [$clog2(DEPTH)-1:0] addr,
  input  wire logic [DW-1:0]            wdata,
  output      logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage : data-memory access plus registered mux-5 writeback record
// Optional macro WB_FWD_EN adds combinational forwarding copies.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DW    = pipe_pkg::DW,
  parameter int DEPTH = 256,
  parameter int RW    = pipe_pkg::RW
) (
  input wire logic      CLOCK,
  input wire logic      in_rst,
  mem_wb_stage_if.slave stg
);

  localparam int AW = $clog2(DEPTH);

  logic          do_rd;
  logic          do_wr;
  logic          do_m5;
  logic          oor;
  logic          illegal;
  logic [3:0]    op;
  logic [AW-1:0] idx;
  logic [DW-1:0] rdata;
  logic          store_ok;
  logic          mem_we;
  logic          err_d;
  logic          err_q;
  wb_rec_t       wb_d;
  wb_rec_t       wb_q;

  // Bubbles mask every control strobe so X on idle inputs cannot leak in.
  assign do_rd = stg.in_valid & stg.in_cntrl_mem_read;
  assign do_wr = stg.in_valid & stg.in_cntrl_mem_write;
  assign do_m5 = stg.in_valid & stg.in_cntrl_m5;
  assign idx   = stg.in_addr_mem[AW-1:0];

  generate
    if (DW > AW) begin : g_range
      assign oor = |stg.in_addr_mem[DW-1:AW];
    end else begin : g_no_range
      assign oor = 1'b0;
    end
  endgenerate

  assign illegal = (do_rd & do_wr) | (do_m5 & (do_rd | do_wr));
  assign op      = mem_op(do_rd, do_wr);

  always_comb begin
    wb_d     = wb_q;
    wb_d.en  = 1'b0;
    err_d    = illegal;
    store_ok = 1'b0;
    if (!illegal) begin
      case (op)
        OP_LW: begin
          if (oor) err_d = 1'b1;
          else     wb_d  = '{en: 1'b1, dest: stg.in_dest_reg, data: rdata};
        end
        OP_SW: begin
          if (oor) err_d    = 1'b1;
          else     store_ok = 1'b1;
        end
        default: begin
          if (do_m5) wb_d = '{en: 1'b1, dest: stg.in_dest_reg, data: stg.in_m5};
        end
      endcase
    end
  end

  // Reset must also block the array write, which has no reset of its own.
  assign mem_we = store_ok & ~in_rst;

  dmem_array #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_dmem (
    .clk   (CLOCK),
    .we    (mem_we),
    .addr  (idx),
    .wdata (stg.in_data_mem),
    .rdata (rdata)
  );

  always_ff @(posedge CLOCK or posedge in_rst) begin
    if (in_rst) begin
      wb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wb_q  <= wb_d;
      err_q <= err_d;
    end
  end

  assign stg.out_wb_data = wb_q.data;
  assign stg.out_wb_reg  = wb_q.dest;
  assign stg.out_wb_en   = wb_q.en;
  assign stg.out_mem_err = err_q;

`ifdef WB_FWD_EN
  assign stg.out_fwd_valid = wb_q.en;
  assign stg.out_fwd_reg   = wb_q.dest;
  assign stg.out_fwd_data  = wb_q.data;
`endif

endmodule

`default_nettype wire
